// File: rtl/regfile_dump.sv
// Sequential read-out engine: walks every register-file address, latching each word and its
// address for display. Optional running checksum of the scanned words under DUMP_CHECKSUM_EN.
module regfile_dump #(
    parameter int ADDR        = 5,
    parameter int SIZE        = 32,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic            Clk,
    input  logic            reset,
    input  logic            start,
    input  logic            auto,
    input  logic            step,
    output logic [ADDR-1:0] R_Addr,
    input  logic [SIZE-1:0] R_Data,
    output logic [SIZE-1:0] Disp_Data,
    output logic [ADDR-1:0] Disp_Addr,
    output logic            busy,
    output logic            done,
`ifdef DUMP_CHECKSUM_EN
    output logic [SIZE-1:0] Checksum,
`endif
    output logic [1:0]      dbg_state
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [ADDR-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHOW, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [ADDR-1:0] r_addr_q, r_addr_d;
    logic [SIZE-1:0] disp_data_q, disp_data_d;
    logic [ADDR-1:0] disp_addr_q, disp_addr_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            auto_q;
    logic            advance;
`ifdef DUMP_CHECKSUM_EN
    logic [SIZE-1:0] checksum_q, checksum_d;
`endif

    // A change of auto since last cycle suppresses a timer advance; the counter restarts instead.
    assign advance = auto ? (auto_q && (hold_cnt_q == HOLD_LAST)) : step;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            r_addr_q    <= '0;
            disp_data_q <= '0;
            disp_addr_q <= '0;
            hold_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            auto_q      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            r_addr_q    <= r_addr_d;
            disp_data_q <= disp_data_d;
            disp_addr_q <= disp_addr_d;
            hold_cnt_q  <= hold_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            auto_q      <= auto;
`ifdef DUMP_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_SHOW;
            S_SHOW:  if (advance) state_d = (r_addr_q == LAST_ADDR) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        r_addr_d    = r_addr_q;
        disp_data_d = disp_data_q;
        disp_addr_d = disp_addr_q;
        hold_cnt_d  = hold_cnt_q;
`ifdef DUMP_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    r_addr_d   = '0;
                    hold_cnt_d = '0;
`ifdef DUMP_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end
            S_FETCH: begin
                disp_data_d = R_Data;
                disp_addr_d = r_addr_q;
                hold_cnt_d  = '0;
`ifdef DUMP_CHECKSUM_EN
                checksum_d  = checksum_q + R_Data;
`endif
            end
            S_SHOW: begin
                if (advance) begin
                    hold_cnt_d = '0;
                    if (r_addr_q != LAST_ADDR) r_addr_d = r_addr_q + ADDR'(1);
                end else if (!auto || !auto_q) begin
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
        busy_d = (state_d == S_FETCH) || (state_d == S_SHOW);
        done_d = (state_d == S_DONE);
    end

    assign R_Addr    = r_addr_q;
    assign Disp_Data = disp_data_q;
    assign Disp_Addr = disp_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;
`ifdef DUMP_CHECKSUM_EN
    assign Checksum  = checksum_q;
`endif

endmodule
